// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared encodings and constants for the multiply/divide sequencer
package multdiv_pkg;

  localparam logic [4:0] OPC_ALU   = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  localparam int unsigned STATUS_REG = 30;
  localparam int unsigned MUL_STATUS = 4;
  localparam int unsigned DIV_STATUS = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_WB    = 2'd3
  } md_state_e;

endpackage

// File: rtl/multdiv_if.sv
// rtl/multdiv_if.sv - multiply/divide unit and register-file write port bundle
interface multdiv_if #(
  parameter int WIDTH = 32
);

  logic             md_start_mult;
  logic             md_start_div;
  logic [WIDTH-1:0] md_a;
  logic [WIDTH-1:0] md_b;
  logic             md_ready;
  logic             md_exception;
  logic [WIDTH-1:0] md_result;

  logic             wb_req;
  logic             wb_grant;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;

  // Sequencer side
  modport master (
    output md_start_mult, md_start_div, md_a, md_b,
    input  md_ready, md_exception, md_result,
    output wb_req, wb_rd, wb_data,
    input  wb_grant
  );

  // Unit / write-port arbiter side
  modport slave (
    input  md_start_mult, md_start_div, md_a, md_b,
    output md_ready, md_exception, md_result,
    input  wb_req, wb_rd, wb_data,
    output wb_grant
  );

endinterface

// File: rtl/multdiv_decode.sv
// rtl/multdiv_decode.sv - gate-level MUL/DIV detector for the X-stage instruction
module multdiv_decode
  import multdiv_pkg::*;
(
  input  logic       x_valid,
  input  logic [4:0] x_opcode,
  input  logic [4:0] x_aluop,
  output logic       is_md,
  output logic       is_div
);

  // MUL and DIV differ only in aluop bit 0, so the upper four bits select the pair
  assign is_md  = x_valid
                & ~|(x_opcode ^ OPC_ALU)
                & ~|(x_aluop[4:1] ^ ALUOP_MUL[4:1]);
  assign is_div = is_md & ~|(x_aluop ^ ALUOP_DIV);

endmodule

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - sequences MUL/DIV through the shared multi-cycle unit and writes back
module multdiv_ctrl #(
  parameter int WIDTH      = 32,
  parameter int TIMEOUT    = 40,
  parameter int MUL_STATUS = 4,
  parameter int DIV_STATUS = 5,
  parameter int STATUS_REG = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_valid,
  input  logic [4:0]       x_opcode,
  input  logic [4:0]       x_aluop,
  input  logic [4:0]       x_rd,
  input  logic [WIDTH-1:0] x_a,
  input  logic [WIDTH-1:0] x_b,
  multdiv_if.master        mif,
  output logic             stall,
  output logic             busy
);
  import multdiv_pkg::*;

  localparam int CW = $clog2(TIMEOUT) + 1;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [4:0]       rd_q, rd_d;
  logic             is_div_q, is_div_d, exc_q, exc_d;

  logic is_md, dec_div, wb_skip;

  multdiv_decode u_decode (
    .x_valid  (x_valid),
    .x_opcode (x_opcode),
    .x_aluop  (x_aluop),
    .is_md    (is_md),
    .is_div   (dec_div)
  );

  // A clean result for r0 is dropped without touching the write port
  assign wb_skip = !exc_q && (rd_q == 5'd0);

  // Operands stay on the unit inputs from START until the next accepted instruction
  assign mif.md_a = a_q;
  assign mif.md_b = b_q;

  // State, counter and latched operation registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    a_d               = a_q;
    b_d               = b_q;
    rd_d              = rd_q;
    is_div_d          = is_div_q;
    result_d          = result_q;
    exc_d             = exc_q;
    mif.md_start_mult = 1'b0;
    mif.md_start_div  = 1'b0;
    mif.wb_req        = 1'b0;
    mif.wb_rd         = '0;
    mif.wb_data       = '0;
    stall             = 1'b0;
    busy              = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (is_md) begin
          a_d      = x_a;
          b_d      = x_b;
          rd_d     = x_rd;
          is_div_d = dec_div;
          result_d = '0;
          exc_d    = 1'b0;
          stall    = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        mif.md_start_div  = is_div_q;
        mif.md_start_mult = !is_div_q;
        cnt_d             = '0;
        stall             = 1'b1;
        state_d           = ST_BUSY;
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        stall = 1'b1;
        if (mif.md_ready) begin
          result_d = mif.md_result;
          exc_d    = mif.md_exception;
          state_d  = ST_WB;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          exc_d   = 1'b1;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        mif.wb_req = !wb_skip;
        if (exc_q) begin
          mif.wb_rd   = 5'(STATUS_REG);
          mif.wb_data = is_div_q ? WIDTH'(DIV_STATUS) : WIDTH'(MUL_STATUS);
        end else begin
          mif.wb_rd   = rd_q;
          mif.wb_data = result_q;
        end
        // Stall releases in the completion cycle so X retires at this edge
        stall = !(mif.wb_grant || wb_skip);
        if (mif.wb_grant || wb_skip) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
